vga_scan_engine: RTL and testbench

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

---
 rtl/vga_scan_engine.sv | 123 ++++++++++++
 tb/tb_vga_scan_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA timing, framebuffer addressing and RGB565 output pipeline.
// Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar input.
module vga_scan_engine #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   CLK_DIV   = 2,
  parameter int   SCALE     = 3,
  parameter int   BASE_ADDR = 0,
  parameter int   ADDR_W    = 16,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic [15:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pix_en,
  output logic              pix_clk,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic [7:0]        rgb_r,
  output logic [7:0]        rgb_g,
  output logic [7:0]        rgb_b,
  output logic              frame_start,
  output logic [15:0]       hpos,
  output logic [15:0]       vpos
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  logic [DW-1:0] div_q, div_d;
  logic [15:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr0;
  logic fs_q, fs_d, hs1_q, hs1_d, vs1_q, vs1_d, bl1_q, bl1_d;
  logic hs2_q, hs2_d, vs2_q, vs2_d, bl2_q, bl2_d;
  logic h_wrap, v_wrap, hs0, vs0, bl0;
  logic [23:0] rgb_q, rgb_d, pix_rgb, mem_rgb;
`ifdef VGA_TEST_PATTERN_EN
  // Bar colours packed {r,g,b} per index, index 0 in the low bits.
  localparam logic [23:0] BARS = 24'b000_001_100_101_010_011_110_111;
  logic [15:0] x1_q, x1_d;
  logic [2:0] bar_idx, bar;
`endif
  always_comb begin
    pix_en  = div_q == DIV_MAX;
    h_wrap  = hpos_q == 16'(H_TOTAL - 1);
    v_wrap  = vpos_q == 16'(V_TOTAL - 1);
    hs0     = hpos_q >= 16'(H_ACTIVE + H_FP) && hpos_q < 16'(H_ACTIVE + H_FP + H_SYNC);
    vs0     = vpos_q >= 16'(V_ACTIVE + V_FP) && vpos_q < 16'(V_ACTIVE + V_FP + V_SYNC);
    bl0     = hpos_q < 16'(H_ACTIVE) && vpos_q < 16'(V_ACTIVE);
    addr0   = ADDR_W'(BASE_ADDR) + ADDR_W'(vpos_q >> SCALE) * ADDR_W'(H_ACTIVE >> SCALE)
            + ADDR_W'(hpos_q >> SCALE);
    mem_rgb = {mem_data[15:11], mem_data[15:13], mem_data[10:5], mem_data[10:9],
               mem_data[4:0], mem_data[4:2]};
`ifdef VGA_TEST_PATTERN_EN
    bar_idx = 3'((32'(x1_q) * 8) / H_ACTIVE);
    bar     = BARS[3*bar_idx +: 3];
    pix_rgb = test_mode ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : mem_rgb;
    x1_d    = pix_en ? hpos_q : x1_q;
`else
    pix_rgb = mem_rgb;
`endif
    div_d   = pix_en ? '0 : div_q + 1'b1;
    hpos_d  = !pix_en ? hpos_q : h_wrap ? '0 : hpos_q + 16'd1;
    vpos_d  = !(pix_en && h_wrap) ? vpos_q : v_wrap ? '0 : vpos_q + 16'd1;
    fs_d    = pix_en && h_wrap && v_wrap;
    // The address only follows visible pixels, so it parks at the last one during blanking.
    addr_d  = pix_en && bl0 ? addr0 : addr_q;
    hs1_d   = pix_en ? hs0 : hs1_q;
    vs1_d   = pix_en ? vs0 : vs1_q;
    bl1_d   = pix_en ? bl0 : bl1_q;
    hs2_d   = pix_en ? hs1_q : hs2_q;
    vs2_d   = pix_en ? vs1_q : vs2_q;
    bl2_d   = pix_en ? bl1_q : bl2_q;
    rgb_d   = !pix_en ? rgb_q : (bl1_q && video_en) ? pix_rgb : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      hpos_q <= '0;
      vpos_q <= '0;
      fs_q   <= 1'b0;
      addr_q <= ADDR_W'(BASE_ADDR);
      {hs1_q, vs1_q, bl1_q, hs2_q, vs2_q, bl2_q} <= '0;
      rgb_q  <= '0;
`ifdef VGA_TEST_PATTERN_EN
      x1_q   <= '0;
`endif
    end else begin
      div_q  <= div_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      fs_q   <= fs_d;
      addr_q <= addr_d;
      {hs1_q, vs1_q, bl1_q, hs2_q, vs2_q, bl2_q} <= {hs1_d, vs1_d, bl1_d, hs2_d, vs2_d, bl2_d};
      rgb_q  <= rgb_d;
`ifdef VGA_TEST_PATTERN_EN
      x1_q   <= x1_d;
`endif
    end
  end
  assign pix_clk     = div_q < DIV_HALF;
  assign mem_addr    = addr_q;
  assign hsync       = hs2_q ? SYNC_POL : ~SYNC_POL;
  assign vsync       = vs2_q ? SYNC_POL : ~SYNC_POL;
  assign blank_n     = bl2_q;
  assign {rgb_r, rgb_g, rgb_b} = rgb_q;
  assign frame_start = fs_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: scoreboard bench for vga_scan_engine on a reduced raster.
module tb_vga_scan_engine;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
  localparam int CD = 3, SC = 1, BASE = 100, AW = 12;
  localparam logic POL = 1'b0;
  localparam int FRAME = HT * VT * CD;
  typedef struct packed {logic hs; logic vs; logic bl; logic [AW-1:0] a; logic [15:0] x;} ent_t;
  logic clk = 0, reset = 1, video_en = 1, test_mode = 0, ovr_en = 0;
  logic [15:0] ovr = 0, mem_data;
  logic [AW-1:0] mem_addr;
  logic pix_en, pix_clk, hsync, vsync, blank_n, frame_start;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic [15:0] hpos, vpos;
  int checks = 0, errors = 0;
  int m_div, m_x, m_y;
  logic [AW-1:0] m_addr;
  logic m_fs, e_hs, e_vs, e_bl;
  logic [23:0] e_rgb;
  ent_t sb[$];
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_scan_engine #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA),
    .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CLK_DIV(CD), .SCALE(SC), .BASE_ADDR(BASE),
    .ADDR_W(AW), .SYNC_POL(POL)) dut (
    .clk(clk), .reset(reset), .video_en(video_en),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .mem_data(mem_data), .mem_addr(mem_addr), .pix_en(pix_en), .pix_clk(pix_clk),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .rgb_r(rgb_r), .rgb_g(rgb_g),
    .rgb_b(rgb_b), .frame_start(frame_start), .hpos(hpos), .vpos(vpos));

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
    return ovr_en ? ovr : ({4'h0, a} * 16'd40503) ^ 16'h5A3C;
  endfunction

  always @(posedge clk) mem_data <= mem_f(mem_addr);

  function automatic logic [23:0] expand(input logic [15:0] d);
    logic [7:0] r, g, b;
    r = 8'(d[15:11]) * 8'd8 + 8'(d[15:11] >> 2);
    g = 8'(d[10:5]) * 8'd4 + 8'(d[10:5] >> 4);
    b = 8'(d[4:0]) * 8'd8 + 8'(d[4:0] >> 2);
    return {r, g, b};
  endfunction

  function automatic ent_t ent(input int x, input int y);
    ent_t e;
    e.hs = x >= HA + HFP && x < HA + HFP + HS;
    e.vs = y >= VA + VFP && y < VA + VFP + VS;
    e.bl = x < HA && y < VA;
    e.a  = AW'(BASE + (y / (1 << SC)) * (HA / (1 << SC)) + x / (1 << SC));
    e.x  = 16'(x);
    return e;
  endfunction

  // Advances one clk and the reference model; the queue carries each pixel from S0 to S2.
  task automatic tick();
    ent_t p, o;
    @(posedge clk);
    if (reset) begin
      m_div = 0; m_x = 0; m_y = 0; m_addr = AW'(BASE); m_fs = 0;
      sb.delete();
      sb.push_back('0);
      {e_hs, e_vs, e_bl, e_rgb} = '0;
    end else if (m_div == CD - 1) begin
      p = ent(m_x, m_y);
      sb.push_back(p);
      o = sb.pop_front();
      {e_hs, e_vs, e_bl} = {o.hs, o.vs, o.bl};
      e_rgb = !(o.bl && video_en) ? 24'h0 : test_mode ? bars[(int'(o.x) * 8) / HA] : expand(mem_f(o.a));
      m_fs = m_x == HT - 1 && m_y == VT - 1;
      if (p.bl) m_addr = p.a;
      m_x = (m_x == HT - 1) ? 0 : m_x + 1;
      if (m_x == 0) m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      m_div = 0;
    end else begin
      m_div++;
      m_fs = 0;
    end
  endtask

  task automatic test_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      #1;
      checks++;
      if ({hpos, vpos, pix_en, pix_clk, frame_start} !==
          {16'(m_x), 16'(m_y), m_div == CD - 1, m_div < CD / 2, m_fs}) begin
        errors++;
        $display("FAIL timing t=%0t got pos=%0d,%0d en=%b pclk=%b fs=%b want %0d,%0d en=%b pclk=%b fs=%b",
          $time, hpos, vpos, pix_en, pix_clk, frame_start, m_x, m_y, m_div == CD - 1, m_div < CD / 2, m_fs);
      end
      checks++;
      if (mem_addr !== m_addr) begin
        errors++;
        $display("FAIL mem_addr t=%0t got %0d want %0d", $time, mem_addr, m_addr);
      end
      checks++;
      if ({hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b} !==
          {e_hs ? POL : ~POL, e_vs ? POL : ~POL, e_bl, e_rgb}) begin
        errors++;
        $display("FAIL video t=%0t got hs=%b vs=%b bn=%b rgb=%h%h%h want hs=%b vs=%b bn=%b rgb=%h",
          $time, hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b, e_hs ? POL : ~POL, e_vs ? POL : ~POL, e_bl, e_rgb);
      end
    end
  endtask

  task automatic test_reset();
    int first = -1;
    reset = 1;
    repeat (3) tick();
    #1;
    checks++;
    if ({hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b, frame_start, hpos, vpos, mem_addr} !==
        {~POL, ~POL, 1'b0, 24'h0, 1'b0, 32'h0, 12'd100}) begin
      errors++;
      $display("FAIL reset_state got hs=%b vs=%b bn=%b rgb=%h%h%h fs=%b pos=%0d,%0d addr=%0d want inactive/0/addr 100",
        hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b, frame_start, hpos, vpos, mem_addr);
    end
    reset = 0;
    for (int i = 1; i <= CD + 2; i++) begin
      tick();
      #1;
      if (hpos !== 16'd0 && first < 0) first = i;
    end
    checks++;
    if (first != CD) begin
      errors++;
      $display("FAIL first_pix_en got hpos step after %0d clks want %0d", first, CD);
    end
  endtask

  task automatic test_timing();
    int t = 0, h_fall = -1, v_fall = -1, fs_t = -1;
    int line = 0, hs_low = 0, vs_low = 0, fs_per = 0, pc_high = 0, fs_wide = 0;
    logic ph = 1, pv = 1, pf = 0;
    for (int i = 0; i < 2 * FRAME + 100; i++) begin
      tick();
      #1;
      t++;
      if (t <= CD * 4 && pix_clk === 1'b1) pc_high++;
      if (ph === 1'b1 && hsync === 1'b0) begin
        if (h_fall >= 0) line = t - h_fall;
        h_fall = t;
      end
      if (ph === 1'b0 && hsync === 1'b1 && h_fall >= 0) hs_low = t - h_fall;
      if (pv === 1'b1 && vsync === 1'b0) v_fall = t;
      if (pv === 1'b0 && vsync === 1'b1 && v_fall >= 0) vs_low = t - v_fall;
      if (frame_start === 1'b1) begin
        if (pf === 1'b1) fs_wide++;
        if (fs_t >= 0) fs_per = t - fs_t;
        fs_t = t;
      end
      {ph, pv, pf} = {hsync, vsync, frame_start};
    end
    checks++;
    if ({line, hs_low, vs_low, fs_per, fs_wide, pc_high} !== {HT * CD, HS * CD, VS * HT * CD, FRAME, 0, 4 * (CD / 2)}) begin
      errors++;
      $display("FAIL periods got line=%0d hs_low=%0d vs_low=%0d frame=%0d fs_wide=%0d pclk_hi=%0d want %0d %0d %0d %0d 0 %0d",
        line, hs_low, vs_low, fs_per, fs_wide, pc_high, HT * CD, HS * CD, VS * HT * CD, FRAME, 4 * (CD / 2));
    end
  endtask

  task automatic test_video_en();
    video_en = 0;
    test_pixels(400);
    test_timing();
    video_en = 1;
    test_pixels(2 * CD);
  endtask

  task automatic test_addr_points();
    int hits = 0;
    logic [AW-1:0] want;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      #1;
      if (m_div == 0 && ((m_y == 0 && (m_x == 1 || m_x == 3)) || (m_y == VA - 1 && m_x == HA))) begin
        want = (m_x == 1) ? 12'd100 : (m_x == 3) ? 12'd101 : 12'd131;
        hits++;
        checks++;
        if (mem_addr !== want) begin
          errors++;
          $display("FAIL addr_point at S0 %0d,%0d got %0d want %0d", m_x, m_y, mem_addr, want);
        end
      end
    end
    checks++;
    if (hits != 3) begin
      errors++;
      $display("FAIL addr_point_count got %0d want 3", hits);
    end
  endtask

  task automatic test_colors();
    logic [15:0] pats[2] = '{16'hF800, 16'h07E0};
    logic [23:0] want[2] = '{24'hFF0000, 24'h00FF00};
    bit found;
    for (int k = 0; k < 2; k++) begin
      ovr = pats[k];
      ovr_en = 1;
      repeat (2 * CD) tick();
      found = 0;
      for (int i = 0; i < FRAME && !found; i++) begin
        tick();
        #1;
        if (blank_n === 1'b1) begin
          found = 1;
          checks++;
          if ({rgb_r, rgb_g, rgb_b} !== want[k]) begin
            errors++;
            $display("FAIL color_%h got %h%h%h want %h", pats[k], rgb_r, rgb_g, rgb_b, want[k]);
          end
        end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL color_%h got no active pixel want one within %0d clks", pats[k], FRAME);
      end
    end
    test_pixels(300);
    ovr_en = 0;
    repeat (2 * CD) tick();
  endtask

  task automatic test_mid_reset();
    int i = 0;
    while (!(m_div == 0 && m_x == 10 && m_y == 5) && i < FRAME + 10) begin
      tick();
      i++;
    end
    #1;
    reset = 1;
    tick();
    #1;
    checks++;
    if ({hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b, hpos, vpos, mem_addr} !==
        {~POL, ~POL, 1'b0, 24'h0, 32'h0, 12'd100} || i >= FRAME + 10) begin
      errors++;
      $display("FAIL mid_reset got hs=%b vs=%b bn=%b rgb=%h%h%h pos=%0d,%0d addr=%0d want inactive/0/0,0/100",
        hsync, vsync, blank_n, rgb_r, rgb_g, rgb_b, hpos, vpos, mem_addr);
    end
    reset = 0;
    test_pixels(FRAME + 60);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int hits = 0;
    logic [23:0] want;
    test_mode = 1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      #1;
      if (m_div == 0 && m_y == 1 && (m_x == 2 || m_x == HA + 1)) begin
        want = (m_x == 2) ? 24'hFFFFFF : 24'h000000;
        hits++;
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== want) begin
          errors++;
          $display("FAIL bar_x%0d got %h%h%h want %h", m_x - 2, rgb_r, rgb_g, rgb_b, want);
        end
      end
    end
    checks++;
    if (hits != 2) begin
      errors++;
      $display("FAIL bar_count got %0d want 2", hits);
    end
    test_pixels(FRAME);
    test_mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_pixels(FRAME + 100);
    test_timing();
    test_video_en();
    test_addr_points();
    test_colors();
    test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
